// File: rtl/lc3b_types.sv
// ============================================================================
//  Module      : lc3b_types
//  Description : LC-3b opcode encoding and BTB update record shared by the
//                branch-target-buffer update path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] target;
    } btb_upd_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } btb_ctrl_state_t;

    // Only control-transfer instructions carry a target worth caching.
    function automatic logic is_btb_op(input lc3b_opcode op);
        return (op == op_br) || (op == op_jmp) || (op == op_jsr) || (op == op_trap);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_upd_fifo.sv
// ============================================================================
//  Module      : btb_upd_fifo
//  Description : Power-of-two FIFO of pending BTB updates with flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_upd_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     push_i,
    input  btb_upd_t push_data_i,
    input  logic     pop_i,
    output btb_upd_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    btb_upd_t    mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
// ============================================================================
//  Module      : btb_update_ctrl
//  Description : Queues resolved branch targets and writes them into the BTB,
//                or sweeps every BTB set invalid on request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_update_ctrl
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    parameter int LINES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [15:0]              upd_pc,
    input  lc3b_opcode               upd_opcode,
    input  logic [15:0]              upd_alu_out,
    input  logic [15:0]              upd_mem_data,
    input  logic                     inval_req,
    output logic                     inval_busy,
    output logic                     btb_we,
    output logic [15:0]              btb_pc,
    output logic [15:0]              btb_target,
    output logic                     btb_inval,
    output logic [$clog2(LINES)-1:0] btb_inval_index
);

    localparam int            IW       = $clog2(LINES);
    localparam logic [IW-1:0] LAST_IDX = IW'(LINES - 1);

    btb_ctrl_state_t state_q;
    logic            btb_we_q;
    logic [15:0]     btb_pc_q;
    logic [15:0]     btb_target_q;
    logic            btb_inval_q;
    logic            inval_busy_q;
    logic [IW-1:0]   idx_q;

    logic     w_full;
    logic     w_empty;
    logic     w_sweep_start;
    logic     w_push;
    logic     w_pop;
    btb_upd_t w_push_data;
    btb_upd_t w_head;

    // An invalidate starting on this edge wins over both drain and enqueue.
    assign w_sweep_start = (state_q == ST_IDLE) && inval_req;
    assign w_push        = upd_valid && upd_ready && is_btb_op(upd_opcode) && !w_sweep_start;
    assign w_pop         = (state_q == ST_IDLE) && !inval_req && !w_empty;

    assign w_push_data.pc     = upd_pc;
    assign w_push_data.target = (upd_opcode == op_trap) ? upd_mem_data : upd_alu_out;

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (w_sweep_start),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            btb_we_q     <= 1'b0;
            btb_pc_q     <= '0;
            btb_target_q <= '0;
            btb_inval_q  <= 1'b0;
            inval_busy_q <= 1'b0;
            idx_q        <= '0;
        end else begin
            btb_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inval_req) begin
                        state_q      <= ST_SWEEP;
                        btb_inval_q  <= 1'b1;
                        inval_busy_q <= 1'b1;
                        idx_q        <= '0;
                    end else if (!w_empty) begin
                        btb_we_q     <= 1'b1;
                        btb_pc_q     <= w_head.pc;
                        btb_target_q <= w_head.target;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == LAST_IDX) begin
                        state_q      <= ST_IDLE;
                        btb_inval_q  <= 1'b0;
                        inval_busy_q <= 1'b0;
                        idx_q        <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign upd_ready       = !w_full;
    assign btb_we          = btb_we_q;
    assign btb_pc          = btb_pc_q;
    assign btb_target      = btb_target_q;
    assign btb_inval       = btb_inval_q;
    assign inval_busy      = inval_busy_q;
    assign btb_inval_index = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
// ============================================================================
//  Module      : tb_btb_update_ctrl
//  Description : Self-checking bench for btb_update_ctrl against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_update_ctrl;
    import lc3b_types::*;

    localparam int DEPTH = 4;
    localparam int LINES = 32;
    localparam int IW    = $clog2(LINES);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [15:0]   upd_pc = '0;
    lc3b_opcode    upd_opcode = op_add;
    logic [15:0]   upd_alu_out = '0;
    logic [15:0]   upd_mem_data = '0;
    logic          inval_req = 1'b0;
    logic          inval_busy;
    logic          btb_we;
    logic [15:0]   btb_pc;
    logic [15:0]   btb_target;
    logic          btb_inval;
    logic [IW-1:0] btb_inval_index;

    btb_update_ctrl #(.DEPTH(DEPTH), .LINES(LINES)) dut (
        .clk             (clk),
        .rst             (rst),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_pc          (upd_pc),
        .upd_opcode      (upd_opcode),
        .upd_alu_out     (upd_alu_out),
        .upd_mem_data    (upd_mem_data),
        .inval_req       (inval_req),
        .inval_busy      (inval_busy),
        .btb_we          (btb_we),
        .btb_pc          (btb_pc),
        .btb_target      (btb_target),
        .btb_inval       (btb_inval),
        .btb_inval_index (btb_inval_index)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a plain queue of pending updates plus a sweep position.
    btb_upd_t    mq[$];
    bit          sw_on = 0;
    int          sw_idx = 0;
    logic        e_we = 0;
    logic [15:0] e_pc = '0;
    logic [15:0] e_tgt = '0;

    function automatic bit ctl_op(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h4) || (op == 4'hC) || (op == 4'hF);
    endfunction

    task automatic model_step();
        bit       acc;
        btb_upd_t item;
        btb_upd_t nw;
        if (rst) begin
            mq.delete();
            sw_on  = 0;
            sw_idx = 0;
            e_we   = 0;
            return;
        end
        acc       = upd_valid && (mq.size() < DEPTH);
        nw.pc     = upd_pc;
        nw.target = (upd_opcode == 4'hF) ? upd_mem_data : upd_alu_out;
        e_we      = 0;
        if (sw_on) begin
            if (sw_idx == LINES - 1) begin
                sw_on  = 0;
                sw_idx = 0;
            end else begin
                sw_idx++;
            end
            if (acc && ctl_op(upd_opcode)) mq.push_back(nw);
        end else if (inval_req) begin
            mq.delete();
            sw_on  = 1;
            sw_idx = 0;
        end else begin
            if (mq.size() > 0) begin
                item  = mq.pop_front();
                e_we  = 1;
                e_pc  = item.pc;
                e_tgt = item.target;
            end
            if (acc && ctl_op(upd_opcode)) mq.push_back(nw);
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // Observed write log and sweep-run bookkeeping for directed checks.
    typedef struct {
        int          c;
        logic [15:0] pc;
        logic [15:0] tgt;
    } wr_t;
    wr_t wlog[$];
    int  run_len    = 0;
    int  last_run   = 0;
    int  inval_seen = 0;

    always @(negedge clk) begin
        wr_t w;
        chk("upd_ready", {31'd0, upd_ready}, {31'd0, (mq.size() < DEPTH)});
        chk("btb_we", {31'd0, btb_we}, {31'd0, e_we});
        chk("btb_inval", {31'd0, btb_inval}, {31'd0, sw_on});
        chk("inval_busy", {31'd0, inval_busy}, {31'd0, sw_on});
        chk("we_inval_excl", {31'd0, btb_we & btb_inval}, 32'd0);
        if (sw_on) chk("inval_index", 32'(btb_inval_index), 32'(sw_idx));
        if (e_we) begin
            chk("btb_pc", {16'd0, btb_pc}, {16'd0, e_pc});
            chk("btb_target", {16'd0, btb_target}, {16'd0, e_tgt});
        end
        if (btb_we === 1'b1) begin
            w.c = cyc; w.pc = btb_pc; w.tgt = btb_target;
            wlog.push_back(w);
        end
        if (btb_inval === 1'b1) begin
            run_len++;
            inval_seen++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic offer(input logic [15:0] pc, input logic [3:0] op,
                         input logic [15:0] alu, input logic [15:0] mem,
                         output int acc_cyc);
        upd_pc       = pc;
        upd_opcode   = lc3b_opcode'(op);
        upd_alu_out  = alu;
        upd_mem_data = mem;
        upd_valid    = 1'b1;
        acc_cyc      = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (upd_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
        end
        upd_valid = 1'b0;
        if (acc_cyc < 0) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_inval();
        @(posedge clk); #1;
        inval_req = 1'b1;
        @(posedge clk); #1;
        inval_req = 1'b0;
    endtask

    task automatic wait_idx(input int idx);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (btb_inval === 1'b1 && int'(btb_inval_index) == idx) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_idx_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string nm, input int k, input logic [15:0] pc);
        if (k < wlog.size()) chk(nm, {16'd0, wlog[k].pc}, {16'd0, pc});
        else chk({nm, "_missing"}, 32'd0, 32'd1);
    endtask

    initial begin
        int a;
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'd0, btb_we}, 32'd0);
        chk("rst_busy", {31'd0, inval_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, upd_ready}, 32'd1);

        // Single BR: write appears one cycle after the edge following acceptance.
        @(posedge clk); #1;
        offer(16'h3000, 4'h0, 16'h3040, 16'h0000, a);
        repeat (4) @(posedge clk);
        #1;
        chk("br_count", 32'(wlog.size()), 32'd1);
        chk_log("br_pc", 0, 16'h3000);
        if (wlog.size() > 0) begin
            chk("br_target", {16'd0, wlog[0].tgt}, 32'h3040);
            chk("br_latency", 32'(wlog[0].c), 32'(a + 1));
        end

        // TRAP takes mem_data; ADD is accepted but never written.
        offer(16'h1002, 4'hF, 16'hBEEF, 16'h0400, a);
        offer(16'h5555, 4'h1, 16'h1111, 16'h2222, a);
        repeat (5) @(posedge clk);
        #1;
        chk("trap_add_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 1) chk("trap_target", {16'd0, wlog[1].tgt}, 32'h0400);

        // Fill the queue while a sweep blocks draining.
        base = wlog.size();
        pulse_inval();
        offer(16'h0010, 4'h0, 16'h0011, 16'h0, a);
        offer(16'h0020, 4'h4, 16'h0021, 16'h0, a);
        offer(16'h0030, 4'hC, 16'h0031, 16'h0, a);
        offer(16'h0040, 4'h0, 16'h0041, 16'h0, a);
        upd_pc = 16'h0050; upd_opcode = op_br; upd_alu_out = 16'h0051; upd_valid = 1'b1;
        @(negedge clk);
        chk("full_ready", {31'd0, upd_ready}, 32'd0);
        offer(16'h0050, 4'h0, 16'h0051, 16'h0, a);
        repeat (10) @(posedge clk);
        #1;
        chk_log("full_w0", base + 0, 16'h0010);
        chk_log("full_w1", base + 1, 16'h0020);
        chk_log("full_w2", base + 2, 16'h0030);
        chk_log("full_w3", base + 3, 16'h0040);
        chk_log("full_w4", base + 4, 16'h0050);
        if (wlog.size() >= base + 5)
            chk("full_back_to_back", 32'(wlog[base + 4].c - wlog[base].c), 32'd4);

        // Two entries queued in IDLE when an invalidate arrives are discarded.
        base = wlog.size();
        pulse_inval();
        offer(16'h0060, 4'h0, 16'h0061, 16'h0, a);
        offer(16'h0070, 4'h0, 16'h0071, 16'h0, a);
        wait_idx(LINES - 1);
        inval_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        inval_req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("sweep_len", 32'(last_run), 32'd32);
        chk("discarded", 32'(wlog.size()), 32'(base));

        // Asynchronous reset in mid-sweep clears outputs at once; no resumption.
        pulse_inval();
        wait_idx(10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, btb_we}, 32'd0);
        chk("arst_inval", {31'd0, btb_inval}, 32'd0);
        chk("arst_busy", {31'd0, inval_busy}, 32'd0);
        chk("arst_pc", {16'd0, btb_pc}, 32'd0);
        chk("arst_target", {16'd0, btb_target}, 32'd0);
        chk("arst_index", 32'(btb_inval_index), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        inval_seen = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_resume", 32'(inval_seen), 32'd0);

        // Mixed traffic checked cycle by cycle against the model.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            upd_valid    = ($urandom_range(0, 3) != 0);
            upd_opcode   = lc3b_opcode'(4'($urandom_range(0, 15)));
            upd_pc       = 16'($urandom);
            upd_alu_out  = 16'($urandom);
            upd_mem_data = 16'($urandom);
            inval_req    = ($urandom_range(0, 60) == 0);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        inval_req = 1'b0;
        repeat (45) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-002 SHALL have parameter LINES, default 32, meaning BTB sets swept on invalidate.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port upd_valid  input  1  writeback stage offers a resolved, valid instruction.
REQ-006 SHALL have port upd_ready  output  1  controller accepts the offer this cycle.
REQ-007 SHALL have port upd_pc  input  16  PC of the offered instruction.
REQ-008 SHALL have port upd_opcode  input  4 (lc3b_opcode)  opcode of the offered instruction.
REQ-009 SHALL have port upd_alu_out  input  16  computed target for BR/JMP/JSR.
REQ-010 SHALL have port upd_mem_data  input  16  trap-vector target for TRAP.
REQ-011 SHALL have port inval_req  input  1  request to invalidate the whole BTB.
REQ-012 SHALL have port inval_busy  output  1  invalidate sweep in progress.
REQ-013 SHALL have port btb_we  output  1  write one BTB entry this cycle.
REQ-014 SHALL have port btb_pc  output  16  PC for the BTB write.
REQ-015 SHALL have port btb_target  output  16  target for the BTB write.
REQ-016 SHALL have port btb_inval  output  1  clear valid bits of every way of one set this cycle.
REQ-017 SHALL have port btb_inval_index  output  5 ($clog2(LINES))  set being invalidated.

Function
REQ-018 SHALL accept an offer on a rising edge where upd_valid=1 and upd_ready=1.
REQ-019 SHALL drive upd_ready = !full; no enqueue when full, even if a pop occurs in the same cycle.
REQ-020 SHALL enqueue an accepted offer only if upd_opcode is op_br, op_jmp, op_jsr or op_trap; other accepted opcodes SHALL be dropped.
REQ-021 SHALL store target = upd_mem_data for op_trap, else upd_alu_out.
REQ-022 SHALL implement FSM states IDLE and SWEEP.
REQ-023 In IDLE with inval_req=0 and queue non-empty, SHALL pop the head at the edge; btb_we=1 with head pc/target registered for the following cycle only; otherwise btb_we=0.
REQ-024 Latency: an entry accepted into an empty queue at edge E SHALL appear on btb_we in the cycle after edge E+1; sustained drain rate one entry per cycle.
REQ-025 Queue order SHALL be FIFO; pointers SHALL wrap modulo DEPTH; simultaneous push and pop when non-full, non-empty SHALL keep occupancy constant.
REQ-026 In IDLE with inval_req=1, SHALL enter SWEEP (inval_req has priority over drain), empty the queue, and discard any offer accepted on that same edge.
REQ-027 In SWEEP SHALL drive btb_inval=1 and btb_inval_index = 0,1,...,LINES-1 on consecutive cycles, then return to IDLE; btb_we=0 throughout.
REQ-028 inval_busy SHALL be 1 exactly during the LINES SWEEP cycles.
REQ-029 inval_req during SWEEP SHALL be ignored; offers during SWEEP SHALL be accepted while not full and drained after SWEEP.
REQ-030 btb_we and btb_inval SHALL never both be 1.

Reset
REQ-031 On rst=1, immediately: state IDLE, queue empty, sweep counter 0, btb_we=0, btb_inval=0, inval_busy=0, btb_pc=0, btb_target=0, btb_inval_index=0; upd_ready=1 once rst deasserts.
REQ-032 rst asserted mid-SWEEP SHALL abort the sweep; no resumption after reset.

Structure
REQ-033 The op_br/op_jmp/op_jsr/op_trap constants and a btb_upd_t struct (pc, target) SHALL live in lc3b_types.
REQ-034 The queue SHALL be a single sub-module btb_upd_fifo (parameter DEPTH, element btb_upd_t, push/pop/full/empty); FSM, filtering and output registers in btb_update_ctrl.

Verification
REQ-035 Single BR: pc=0x3000, alu_out=0x3040 accepted at edge 1 -> btb_we=1, btb_pc=0x3000, btb_target=0x3040 in the cycle after edge 2 only.
REQ-036 TRAP: pc=0x1002, mem_data=0x0400, alu_out=0xBEEF -> btb_target=0x0400; ADD opcode offer -> upd_ready=1, no btb_we.
REQ-037 Full: drain blocked by SWEEP, 4 offers (0x10,0x20,0x30,0x40) -> upd_ready=0, 5th offer held; after SWEEP, writes in order 0x10..0x40 on consecutive cycles, then 5th.
REQ-038 Invalidate: inval_req pulse with 2 queued entries -> 32 cycles btb_inval=1, index 0..31, inval_busy=1, no btb_we; queued entries never written.
REQ-039 Reset: rst asserted at sweep index 10 -> all outputs 0 immediately; after release, no further btb_inval.
REQ-040 Random offers/invalidates vs. reference model: writes in FIFO order, btb_we and btb_inval mutually exclusive, no loss except per REQ-020/026.
